// File: rtl/mc_port_responder.sv
// MC-port responder: quadword RAM answering mc_rq_* requests with RD_DATA/WR_CMP, 3-cycle latency, 1 rsp/cycle.
// mc_rq_stall is advisory with RQ_SLACK headroom; mc_rs_stall holds responses in the FIFO; write flush tracked by count.
module mc_port_responder_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     i_reset,
    input  logic                     push_vld,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop_rdy,
    output logic [W-1:0]             pop_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;

    // Caller guarantees push only with room (or a same-cycle pop) and pop only when non-empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_vld);
        rd_ptr_d = rd_ptr_q + AW'(pop_rdy);
        cnt_d    = cnt_q + (AW+1)'(push_vld) - (AW+1)'(pop_rdy);
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld) mem_q[wr_ptr_q] <= push_dat;
    end

    assign pop_dat = mem_q[rd_ptr_q];
    assign count   = cnt_q;
endmodule

module mc_port_responder #(
    parameter int RTNCTL_WIDTH = 32,
    parameter int ADDR_W       = 10,
    parameter int FIFO_DEPTH   = 16,
    parameter int RQ_SLACK     = 4
) (
    input  logic                    clk,
    input  logic                    i_reset,
    input  logic                    mc_rq_vld,
    input  logic [RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
    input  logic [63:0]             mc_rq_data,
    input  logic [47:0]             mc_rq_vadr,
    input  logic [1:0]              mc_rq_size,
    input  logic [2:0]              mc_rq_cmd,
    input  logic [3:0]              mc_rq_scmd,
    output logic                    mc_rq_stall,
    output logic                    mc_rs_vld,
    output logic [2:0]              mc_rs_cmd,
    output logic [3:0]              mc_rs_scmd,
    output logic [63:0]             mc_rs_data,
    output logic [RTNCTL_WIDTH-1:0] mc_rs_rtnctl,
    input  logic                    mc_rs_stall,
    input  logic                    mc_rq_flush,
    output logic                    mc_rs_flush_cmplt,
    output logic                    o_err
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int PW_W  = $clog2(FIFO_DEPTH) + 3;

    localparam logic [2:0] CMD_RD     = 3'd1;
    localparam logic [2:0] CMD_WR     = 3'd2;
    localparam logic [2:0] RS_RD_DATA = 3'd2;
    localparam logic [2:0] RS_WR_CMP  = 3'd3;

    localparam logic [1:0] FL_IDLE = 2'd0;
    localparam logic [1:0] FL_WAIT = 2'd1;
    localparam logic [1:0] FL_DONE = 2'd2;

    typedef struct packed {
        logic                    is_wr;
        logic [RTNCTL_WIDTH-1:0] rtnctl;
        logic [63:0]             dat;
    } rsp_t;

    logic [63:0] mem_q [2**ADDR_W];

    logic              rq_rd, rq_wr, rq_ill, rq_misal;
    logic [2:0]        align_m;
    logic [7:0]        lanes, rq_mask;

    logic                    p1_vld_q, p1_vld_d;
    logic                    p1_wr_q, p1_wr_d;
    logic                    p1_misal_q, p1_misal_d;
    logic [ADDR_W-1:0]       p1_idx_q, p1_idx_d;
    logic [7:0]              p1_mask_q, p1_mask_d;
    logic [63:0]             p1_data_q, p1_data_d;
    logic [RTNCTL_WIDTH-1:0] p1_rtnctl_q, p1_rtnctl_d;

    logic              ram_we;
    logic [63:0]       rd_dat;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_full, fifo_pop, fifo_push, ovf;
    rsp_t              push_ent, pop_ent;
    logic [CNT_W:0]    occ;

    logic                    rs_vld_q, rs_vld_d;
    logic [2:0]              rs_cmd_q, rs_cmd_d;
    logic [63:0]             rs_data_q, rs_data_d;
    logic [RTNCTL_WIDTH-1:0] rs_rtnctl_q, rs_rtnctl_d;
    logic                    stall_q, stall_d;
    logic                    err_q, err_d;

    logic              wr_dlv, wr_drop;
    logic [PW_W-1:0]   retire;
    logic [PW_W-1:0]   pend_q, pend_d;
    logic [PW_W-1:0]   rem_q, rem_d;
    logic [1:0]        fl_q, fl_d;

    logic unused_sig;
    assign unused_sig = ^{mc_rq_scmd, mc_rq_vadr[47:ADDR_W+3]};

    always_comb begin
        rq_rd  = mc_rq_vld && (mc_rq_cmd == CMD_RD);
        rq_wr  = mc_rq_vld && (mc_rq_cmd == CMD_WR);
        rq_ill = mc_rq_vld && !rq_rd && !rq_wr;
        case (mc_rq_size)
            2'd0:    begin align_m = 3'b000; lanes = 8'h01; end
            2'd1:    begin align_m = 3'b001; lanes = 8'h03; end
            2'd2:    begin align_m = 3'b011; lanes = 8'h0F; end
            default: begin align_m = 3'b111; lanes = 8'hFF; end
        endcase
        rq_misal = (mc_rq_vadr[2:0] & align_m) != 3'd0;
        rq_mask  = lanes << mc_rq_vadr[2:0];

        p1_vld_d    = rq_rd || rq_wr;
        p1_wr_d     = rq_wr;
        p1_misal_d  = rq_misal;
        p1_idx_d    = mc_rq_vadr[ADDR_W+2:3];
        p1_mask_d   = rq_mask;
        p1_data_d   = mc_rq_data;
        p1_rtnctl_d = mc_rq_rtnctl;
    end

    // Stage 1: async RAM read so a read one cycle behind a write sees the written data.
    always_comb begin
        ram_we    = p1_vld_q && p1_wr_q && !p1_misal_q;
        rd_dat    = mem_q[p1_idx_q];
        fifo_full = fifo_cnt == CNT_W'(FIFO_DEPTH);
        fifo_pop  = (fifo_cnt != '0) && !mc_rs_stall;
        fifo_push = p1_vld_q && (!fifo_full || fifo_pop);
        ovf       = p1_vld_q && fifo_full && !fifo_pop;
        push_ent.is_wr  = p1_wr_q;
        push_ent.rtnctl = p1_rtnctl_q;
        push_ent.dat    = p1_wr_q ? 64'd0 : rd_dat;
        occ       = {1'b0, fifo_cnt} + (CNT_W+1)'(p1_vld_q);
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 8; b++) begin
                if (p1_mask_q[b]) mem_q[p1_idx_q][b*8 +: 8] <= p1_data_q[b*8 +: 8];
            end
        end
    end

    mc_port_responder_fifo #(
        .W     ($bits(rsp_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .i_reset  (i_reset),
        .push_vld (fifo_push),
        .push_dat (push_ent),
        .pop_rdy  (fifo_pop),
        .pop_dat  (pop_ent),
        .count    (fifo_cnt)
    );

    always_comb begin
        rs_vld_d    = fifo_pop;
        rs_cmd_d    = rs_cmd_q;
        rs_data_d   = rs_data_q;
        rs_rtnctl_d = rs_rtnctl_q;
        if (fifo_pop) begin
            rs_cmd_d    = pop_ent.is_wr ? RS_WR_CMP : RS_RD_DATA;
            rs_data_d   = pop_ent.dat;
            rs_rtnctl_d = pop_ent.rtnctl;
        end
        stall_d = occ >= (CNT_W+1)'(FIFO_DEPTH - RQ_SLACK);
        err_d   = err_q || rq_ill || ((rq_rd || rq_wr) && rq_misal) || ovf;
    end

    // Writes retire in order, so a flush only needs to count down the writes outstanding at flush time.
    always_comb begin
        wr_dlv  = rs_vld_q && (rs_cmd_q == RS_WR_CMP);
        wr_drop = ovf && p1_wr_q;
        retire  = PW_W'(wr_dlv) + PW_W'(wr_drop);
        pend_d  = pend_q + PW_W'(rq_wr) - retire;
        fl_d    = fl_q;
        rem_d   = rem_q;
        case (fl_q)
            FL_IDLE: begin
                if (mc_rq_flush) begin
                    fl_d  = FL_WAIT;
                    rem_d = pend_d;
                end
            end
            FL_WAIT: begin
                if (rem_q == '0)        fl_d  = FL_DONE;
                else if (retire >= rem_q) rem_d = '0;
                else                    rem_d = rem_q - retire;
            end
            FL_DONE: fl_d = FL_IDLE;
            default: fl_d = FL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            p1_vld_q    <= 1'b0;
            p1_wr_q     <= 1'b0;
            p1_misal_q  <= 1'b0;
            p1_idx_q    <= '0;
            p1_mask_q   <= '0;
            p1_data_q   <= '0;
            p1_rtnctl_q <= '0;
            rs_vld_q    <= 1'b0;
            rs_cmd_q    <= '0;
            rs_data_q   <= '0;
            rs_rtnctl_q <= '0;
            stall_q     <= 1'b0;
            err_q       <= 1'b0;
            pend_q      <= '0;
            rem_q       <= '0;
            fl_q        <= FL_IDLE;
        end else begin
            p1_vld_q    <= p1_vld_d;
            p1_wr_q     <= p1_wr_d;
            p1_misal_q  <= p1_misal_d;
            p1_idx_q    <= p1_idx_d;
            p1_mask_q   <= p1_mask_d;
            p1_data_q   <= p1_data_d;
            p1_rtnctl_q <= p1_rtnctl_d;
            rs_vld_q    <= rs_vld_d;
            rs_cmd_q    <= rs_cmd_d;
            rs_data_q   <= rs_data_d;
            rs_rtnctl_q <= rs_rtnctl_d;
            stall_q     <= stall_d;
            err_q       <= err_d;
            pend_q      <= pend_d;
            rem_q       <= rem_d;
            fl_q        <= fl_d;
        end
    end

    assign mc_rq_stall       = stall_q;
    assign mc_rs_vld         = rs_vld_q;
    assign mc_rs_cmd         = rs_cmd_q;
    assign mc_rs_scmd        = 4'd0;
    assign mc_rs_data        = rs_data_q;
    assign mc_rs_rtnctl      = rs_rtnctl_q;
    assign mc_rs_flush_cmplt = (fl_q == FL_DONE);
    assign o_err             = err_q;
endmodule
